// File: rtl/delay_line_var.sv
// delay_line_var: run-time programmable multi-bit delay line.
// Delays a WIDTH-bit sample stream by 1..MAX_DLY enabled clock cycles using a
// circular buffer. It supports a clock-enable stall and a synchronous flush,
// and out_valid_o marks when the pipeline has filled.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   en_i         sample enable; the line advances one stage when high
//   flush_i      synchronous clear of line contents (keeps programmed delay)
//   dly_sel_i    requested delay in enabled cycles (clamped to 1..MAX_DLY)
//   in_i         input sample
//   out_o        delayed sample, 0 while out_valid_o is low
//   out_valid_o  line filled for the current delay
//   dly_cur_o    effective clamped delay in use
module delay_line_var #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_DLY = 128,
  parameter int unsigned DLY_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [DLY_W-1:0] dly_sel_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic             out_valid_o,
  output logic [DLY_W-1:0] dly_cur_o
);

  localparam int unsigned PTR_W = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam int unsigned AW    = DLY_W + 1;

  logic [WIDTH-1:0] mem_q [MAX_DLY];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DLY_W-1:0] fill_q, fill_d;
  logic [DLY_W-1:0] dly_cur_q, dly_cur_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;

  logic [DLY_W-1:0] eff_c;
  logic [AW-1:0]    rd_sum_c;
  logic [PTR_W-1:0] rd_addr_c;
  logic             mem_we_c;

  // Clamp the requested delay into 1..MAX_DLY.
  always_comb begin
    eff_c = dly_sel_i;
    if (dly_sel_i == '0) begin
      eff_c = DLY_W'(1);
    end else if (dly_sel_i > DLY_W'(MAX_DLY)) begin
      eff_c = DLY_W'(MAX_DLY);
    end
  end

  // Read address (wr_ptr - dly_cur + 1) mod MAX_DLY. Adding MAX_DLY first
  // keeps the sum non-negative, so one conditional subtract wraps it.
  always_comb begin
    rd_sum_c = AW'(wr_ptr_q) + AW'(MAX_DLY) + AW'(1) - AW'(dly_cur_q);
    if (rd_sum_c >= AW'(MAX_DLY)) begin
      rd_sum_c = rd_sum_c - AW'(MAX_DLY);
    end
    rd_addr_c = PTR_W'(rd_sum_c);
  end

  // Next-state logic: a flush or a delay change clears the line and drops
  // the current sample, and the write pointer holds.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    dly_cur_d = dly_cur_q;
    out_d     = out_q;
    valid_d   = valid_q;
    mem_we_c  = 1'b0;

    if (flush_i || (eff_c != dly_cur_q)) begin
      if (!flush_i) begin
        dly_cur_d = eff_c;
      end
      fill_d  = '0;
      out_d   = '0;
      valid_d = 1'b0;
    end else if (en_i) begin
      mem_we_c = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_DLY - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      fill_d   = (fill_q < dly_cur_q) ? fill_q + DLY_W'(1) : fill_q;
      valid_d  = (fill_d == dly_cur_q);
      // With a delay of 1 the output is a plain register on in_i. Otherwise
      // the sample from dly_cur-1 writes ago is read before this write.
      if (!valid_d) begin
        out_d = '0;
      end else if (dly_cur_q == DLY_W'(1)) begin
        out_d = in_i;
      end else begin
        out_d = mem_q[rd_addr_c];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      dly_cur_q <= DLY_W'(1);
      out_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      dly_cur_q <= dly_cur_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
    end
  end

  // Sample buffer. It is not cleared on reset because the output is masked
  // until the line refills.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      mem_q[wr_ptr_q] <= in_i;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = valid_q;
  assign dly_cur_o   = dly_cur_q;

endmodule
